// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports, two write lanes (lane 1 wins), optional zero register, sequential clear engine.
// Read latency 1 cycle with write-first bypass; no backpressure, enable=0 freezes every flop and masks clr_done.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic                       clr_req,
    output logic                       clr_busy,
    output logic                       clr_done
);

    localparam int              DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W:0]           idx_q, idx_d;
    logic [DATA_W-1:0]         mem_q [DEPTH];
    logic [DATA_W-1:0]         mem_d [DEPTH];
    logic [NUM_RD*DATA_W-1:0]  rd_data_q, rd_data_d;
    logic                      wr0_ok, wr1_ok;
    logic [ADDR_W-1:0]         ra;

    // External writes only land in IDLE; address 0 is read-only when hardwired.
    always_comb begin
        wr0_ok = enable && (state_q == IDLE) && we0 && !((ZERO_REG != 0) && (wa0 == '0));
        wr1_ok = enable && (state_q == IDLE) && we1 && !((ZERO_REG != 0) && (wa1 == '0));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mem_d   = mem_q;
        if (enable) begin
            unique case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_d = CLEAR;
                        idx_d   = '0;
                    end
                end
                CLEAR: begin
                    mem_d[idx_q[ADDR_W-1:0]] = '0;
                    idx_d = idx_q + IDX_ONE;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
            // Lane 1 applied last so it wins a same-address collision.
            if (wr0_ok) begin
                mem_d[wa0] = wd0;
            end
            if (wr1_ok) begin
                mem_d[wa1] = wd1;
            end
        end
    end

    // Bypass follows the same lane priority; clear writes are never bypassed.
    always_comb begin
        rd_data_d = rd_data_q;
        ra        = '0;
        if (enable) begin
            for (int k = 0; k < NUM_RD; k++) begin
                ra = rd_addr[k*ADDR_W +: ADDR_W];
                if (wr1_ok && (wa1 == ra)) begin
                    rd_data_d[k*DATA_W +: DATA_W] = wd1;
                end else if (wr0_ok && (wa0 == ra)) begin
                    rd_data_d[k*DATA_W +: DATA_W] = wd0;
                end else begin
                    rd_data_d[k*DATA_W +: DATA_W] = mem_q[ra];
                end
                if ((ZERO_REG != 0) && (ra == '0)) begin
                    rd_data_d[k*DATA_W +: DATA_W] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            rd_data_q <= '0;
            mem_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rd_data_q <= rd_data_d;
            mem_q     <= mem_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign clr_busy = (state_q == CLEAR);
    assign clr_done = (state_q == DONE) && enable;

endmodule
